// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the CPU datapath.
// Steps through fetch (T0-T2) and execute (T3-T6) phases. Every datapath strobe is decoded from
// the current state and the instruction fields held in IR.
//
// Ports:
//   Clock      system clock; all state changes happen on its rising edge
//   Clear      synchronous active-high reset
//   IR         instruction word: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
//   Stop       request a halt once the current instruction completes
//   Start      resume from HALT
//   PCout..LOin  single-bit datapath strobes
//   Rout, Rin  one-hot general-register bus drive / load selects
//   CONTROL    ALU operation code; nonzero only in T4
//   Run        high while executing (T0-T6)
//   Illegal    high during T3 of an undefined opcode
// Parameter MEM_WAIT (0-15) sets the number of extra T1 cycles spent waiting on a memory read.
module control_sequencer #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   input  logic        Start,
   output logic        PCout,
   output logic        IncPC,
   output logic        MARin,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zlowin,
   output logic        Zhighin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIin,
   output logic        LOin,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic [3:0]  CONTROL,
   output logic        Run,
   output logic        Illegal
);

   localparam logic [3:0] WaitLoad = 4'(MEM_WAIT);

   typedef enum logic [3:0] {
      StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic       stop_pending_q, stop_pending_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_muldiv, is_nop, is_halt, is_illegal;
   state_e     done_state;
   logic       unused_ir;

   assign opcode     = IR[31:27];
   assign ra         = IR[26:23];
   assign rb         = IR[22:19];
   assign rc         = IR[18:15];
   assign unused_ir  = ^IR[14:0];

   assign is_alu     = (opcode <= 5'b01001);
   assign is_muldiv  = (opcode == 5'b01010) || (opcode == 5'b01011);
   assign is_nop     = (opcode == 5'b11000);
   assign is_halt    = (opcode == 5'b11001);
   assign is_illegal = !(is_alu || is_muldiv || is_nop || is_halt);

   // Where an instruction goes when it completes: a pending or live Stop diverts it to HALT.
   assign done_state = (stop_pending_q || Stop) ? StHalt : StT0;

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q        <= StReset;
         wait_q         <= 4'd0;
         stop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         stop_pending_q <= stop_pending_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      stop_pending_d = stop_pending_q;
      if (state_q != StHalt) begin
         stop_pending_d = stop_pending_q | Stop;
      end
      case (state_q)
         StReset: state_d = StT0;
         StT0: begin
            state_d = StT1;
            wait_d  = WaitLoad;
         end
         StT1: begin
            if (wait_q == 4'd0) state_d = StT2;
            else                wait_d  = wait_q - 4'd1;
         end
         StT2: state_d = StT3;
         StT3: begin
            if (is_alu || is_muldiv) state_d = StT4;
            else if (is_halt)        state_d = StHalt;
            else                     state_d = done_state;
         end
         StT4: state_d = StT5;
         StT5: state_d = is_muldiv ? StT6 : done_state;
         StT6: state_d = done_state;
         StHalt: begin
            if (Start) begin
               state_d        = StT0;
               stop_pending_d = 1'b0;
            end
         end
         default: state_d = StReset;
      endcase
   end

   always_comb begin
      PCout    = 1'b0;
      IncPC    = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zlowin   = 1'b0;
      Zhighin  = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      Rout     = 16'd0;
      Rin      = 16'd0;
      CONTROL  = 4'd0;
      Illegal  = 1'b0;
      Run      = (state_q != StReset) && (state_q != StHalt);
      case (state_q)
         StT0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            Zlowin = 1'b1;
         end
         StT1: begin
            Read = 1'b1;
            // The counter still holds its load value only in the first T1 cycle.
            if (wait_q == WaitLoad) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
            MDRin = (wait_q == 4'd0);
         end
         StT2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         StT3: begin
            if (is_alu || is_muldiv) begin
               Rout = 16'd1 << rb;
               Yin  = 1'b1;
            end
            Illegal = is_illegal;
         end
         StT4: begin
            Rout    = 16'd1 << rc;
            CONTROL = opcode[3:0];
            Zlowin  = 1'b1;
            Zhighin = 1'b1;
         end
         StT5: begin
            Zlowout = 1'b1;
            if (is_muldiv) LOin = 1'b1;
            else           Rin  = 16'd1 << ra;
         end
         StT6: begin
            Zhighout = 1'b1;
            HIin     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Two instances: dut (MEM_WAIT=0) exercises the
// instruction classes and run control; dut_w (MEM_WAIT=3) exercises the stretched T1 phase.
// All outputs are packed into one vector and compared per cycle against hand-derived values.
module tb_control_sequencer;

   // Strobe masks, in packing order.
   localparam logic [14:0] SPcOut    = 15'h4000;
   localparam logic [14:0] SIncPc    = 15'h2000;
   localparam logic [14:0] SMarIn    = 15'h1000;
   localparam logic [14:0] SPcIn     = 15'h0800;
   localparam logic [14:0] SRead     = 15'h0400;
   localparam logic [14:0] SMdrIn    = 15'h0200;
   localparam logic [14:0] SMdrOut   = 15'h0100;
   localparam logic [14:0] SIrIn     = 15'h0080;
   localparam logic [14:0] SYIn      = 15'h0040;
   localparam logic [14:0] SZlowIn   = 15'h0020;
   localparam logic [14:0] SZhighIn  = 15'h0010;
   localparam logic [14:0] SZlowOut  = 15'h0008;
   localparam logic [14:0] SZhighOut = 15'h0004;
   localparam logic [14:0] SHiIn     = 15'h0002;
   localparam logic [14:0] SLoIn     = 15'h0001;

   localparam logic [14:0] ST0 = SPcOut | SMarIn | SIncPc | SZlowIn;
   localparam logic [14:0] ST2 = SMdrOut | SIrIn;

   localparam logic [31:0] IrAdd  = 32'h0189_0000;
   localparam logic [31:0] IrMul  = 32'h5022_8000;
   localparam logic [31:0] IrHalt = 32'hC800_0000;
   localparam logic [31:0] IrBad  = 32'hF800_0000;

   logic        Clock, Clear, Clear_w, Stop, Start;
   logic [31:0] IR;

   logic PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
   logic Zlowout, Zhighout, HIin, LOin, Run, Illegal;
   logic [15:0] Rout, Rin;
   logic [3:0]  CONTROL;

   logic w_PCout, w_IncPC, w_MARin, w_PCin, w_Read, w_MDRin, w_MDRout, w_IRin, w_Yin;
   logic w_Zlowin, w_Zhighin, w_Zlowout, w_Zhighout, w_HIin, w_LOin, w_Run, w_Illegal;
   logic [15:0] w_Rout, w_Rin;
   logic [3:0]  w_CONTROL;

   logic [63:0] obs, w_obs;
   int          n_cmp = 0;
   int          n_bad = 0;

   assign obs = {11'd0, PCout, IncPC, MARin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin,
                 Zhighin, Zlowout, Zhighout, HIin, LOin, Rout, Rin, CONTROL, Run, Illegal};
   assign w_obs = {11'd0, w_PCout, w_IncPC, w_MARin, w_PCin, w_Read, w_MDRin, w_MDRout, w_IRin,
                   w_Yin, w_Zlowin, w_Zhighin, w_Zlowout, w_Zhighout, w_HIin, w_LOin, w_Rout,
                   w_Rin, w_CONTROL, w_Run, w_Illegal};

   control_sequencer #(.MEM_WAIT(0)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop), .Start(Start),
      .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .PCin(PCin), .Read(Read), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Rout(Rout),
      .Rin(Rin), .CONTROL(CONTROL), .Run(Run), .Illegal(Illegal)
   );

   control_sequencer #(.MEM_WAIT(3)) dut_w (
      .Clock(Clock), .Clear(Clear_w), .IR(IR), .Stop(Stop), .Start(Start),
      .PCout(w_PCout), .IncPC(w_IncPC), .MARin(w_MARin), .PCin(w_PCin), .Read(w_Read),
      .MDRin(w_MDRin), .MDRout(w_MDRout), .IRin(w_IRin), .Yin(w_Yin), .Zlowin(w_Zlowin),
      .Zhighin(w_Zhighin), .Zlowout(w_Zlowout), .Zhighout(w_Zhighout), .HIin(w_HIin),
      .LOin(w_LOin), .Rout(w_Rout), .Rin(w_Rin), .CONTROL(w_CONTROL), .Run(w_Run),
      .Illegal(w_Illegal)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [63:0] exp_vec(input logic [14:0] strb, input logic [15:0] rout,
                                           input logic [15:0] rin, input logic [3:0] ctrl,
                                           input logic run, input logic ill);
      return {11'd0, strb, rout, rin, ctrl, run, ill};
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Walk the fetch phase of dut (MEM_WAIT=0) from T0 into T3, checking T1 and T2.
   task automatic fetch(input string tag);
      tick();
      check_eq({tag, " T1"}, obs, exp_vec(SRead | SZlowOut | SPcIn | SMdrIn, 0, 0, 0, 1, 0));
      tick();
      check_eq({tag, " T2"}, obs, exp_vec(ST2, 0, 0, 0, 1, 0));
      tick();
   endtask

   initial begin
      Clear = 1'b1; Clear_w = 1'b1; Stop = 1'b0; Start = 1'b0; IR = IrAdd;
      #1;
      tick();
      check_eq("reset c1", obs, exp_vec(0, 0, 0, 0, 0, 0));
      tick();
      check_eq("reset c2", obs, exp_vec(0, 0, 0, 0, 0, 0));
      Clear = 1'b0;

      // add R3,R1,R2
      tick();
      check_eq("add T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));
      fetch("add");
      check_eq("add T3", obs, exp_vec(SYIn, 16'h0002, 0, 0, 1, 0));
      tick();
      check_eq("add T4", obs, exp_vec(SZlowIn | SZhighIn, 16'h0004, 0, 4'b0000, 1, 0));
      tick();
      check_eq("add T5", obs, exp_vec(SZlowOut, 0, 16'h0008, 0, 1, 0));
      tick();
      check_eq("add next T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));

      // mul: Rb=R4, Rc=R5, result to HI/LO
      IR = IrMul;
      fetch("mul");
      check_eq("mul T3", obs, exp_vec(SYIn, 16'h0010, 0, 0, 1, 0));
      tick();
      check_eq("mul T4", obs, exp_vec(SZlowIn | SZhighIn, 16'h0020, 0, 4'b1010, 1, 0));
      tick();
      check_eq("mul T5", obs, exp_vec(SZlowOut | SLoIn, 0, 0, 0, 1, 0));
      tick();
      check_eq("mul T6", obs, exp_vec(SZhighOut | SHiIn, 0, 0, 0, 1, 0));
      tick();
      check_eq("mul next T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));

      // halt, then Start
      IR = IrHalt;
      fetch("halt");
      check_eq("halt T3", obs, exp_vec(0, 0, 0, 0, 1, 0));
      tick();
      check_eq("halt HALT", obs, exp_vec(0, 0, 0, 0, 0, 0));
      tick();
      check_eq("halt held", obs, exp_vec(0, 0, 0, 0, 0, 0));
      Start = 1'b1;
      tick();
      Start = 1'b0;
      check_eq("start T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));

      // Stop pulse during T4 of add: instruction finishes, then HALT
      IR = IrAdd;
      fetch("stop");
      tick();
      check_eq("stop T4", obs, exp_vec(SZlowIn | SZhighIn, 16'h0004, 0, 0, 1, 0));
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      check_eq("stop T5", obs, exp_vec(SZlowOut, 0, 16'h0008, 0, 1, 0));
      tick();
      check_eq("stop HALT", obs, exp_vec(0, 0, 0, 0, 0, 0));
      Stop = 1'b1; Start = 1'b1;
      tick();
      Stop = 1'b0; Start = 1'b0;
      check_eq("stop+start T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));

      // Illegal opcode behaves as nop; stop_pending must have been cleared by Start
      IR = IrBad;
      fetch("ill");
      check_eq("ill T3", obs, exp_vec(0, 0, 0, 0, 1, 1));
      tick();
      check_eq("ill next T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));

      // Clear in T4 of add
      IR = IrAdd;
      fetch("clr");
      tick();
      check_eq("clr T4", obs, exp_vec(SZlowIn | SZhighIn, 16'h0004, 0, 0, 1, 0));
      Clear = 1'b1;
      tick();
      Clear = 1'b0;
      check_eq("clr RESET", obs, exp_vec(0, 0, 0, 0, 0, 0));
      tick();
      check_eq("clr T0", obs, exp_vec(ST0, 0, 0, 0, 1, 0));

      // MEM_WAIT=3 instance: T1 stretched to four cycles
      check_eq("w reset", w_obs, exp_vec(0, 0, 0, 0, 0, 0));
      Clear_w = 1'b0;
      tick();
      check_eq("w T0", w_obs, exp_vec(ST0, 0, 0, 0, 1, 0));
      tick();
      check_eq("w T1 c1", w_obs, exp_vec(SRead | SZlowOut | SPcIn, 0, 0, 0, 1, 0));
      for (int i = 2; i <= 3; i++) begin
         tick();
         check_eq($sformatf("w T1 c%0d", i), w_obs, exp_vec(SRead, 0, 0, 0, 1, 0));
      end
      tick();
      check_eq("w T1 c4", w_obs, exp_vec(SRead | SMdrIn, 0, 0, 0, 1, 0));
      tick();
      check_eq("w T2", w_obs, exp_vec(ST2, 0, 0, 0, 1, 0));
      tick();
      check_eq("w T3", w_obs, exp_vec(SYIn, 16'h0002, 0, 0, 1, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
